// File: rtl/ft_pkg.sv
// Shared definitions for the FT2232H synchronous-FIFO controllers:
// default data width and the flush state machine encoding.
package ft_pkg;

  localparam int FT_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FLUSH  = 2'd2
  } flush_state_e;

endpackage

// File: rtl/ft_tx_ctrl_if.sv
// Bus bundle between the transmit controller, the async FIFO read port
// and the FT2232H write side. The master is the controller.
interface ft_tx_ctrl_if import ft_pkg::*; #(
  parameter int DATA_WIDTH = FT_DATA_WIDTH
);

  logic                  fifo_empty;
  logic                  fifo_rden;
  logic [DATA_WIDTH-1:0] fifo_rddata;
  logic                  ft_txe_n;
  logic                  ft_suspend_n;
  logic                  ft_wr_n;
  logic [DATA_WIDTH-1:0] ft_data;
  logic                  ft_siwua_n;

  modport master (
    input  fifo_empty,
    input  fifo_rddata,
    input  ft_txe_n,
    input  ft_suspend_n,
    output fifo_rden,
    output ft_wr_n,
    output ft_data,
    output ft_siwua_n
  );

  modport slave (
    output fifo_empty,
    output fifo_rddata,
    output ft_txe_n,
    output ft_suspend_n,
    input  fifo_rden,
    input  ft_wr_n,
    input  ft_data,
    input  ft_siwua_n
  );

endinterface

// File: rtl/ft_skid_buf.sv
// Two-entry skid FIFO. Entry 0 is always the head. Push and pop may
// happen together, including when full, so a full buffer can stream.
module ft_skid_buf import ft_pkg::*; #(
  parameter int DATA_WIDTH = FT_DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] head_o,
  output logic [1:0]            count_o
);

  logic [DATA_WIDTH-1:0] entry0_q, entry0_d;
  logic [DATA_WIDTH-1:0] entry1_q, entry1_d;
  logic [1:0]            count_q, count_d;
  logic                  do_push;
  logic                  do_pop;

  // Next-state for the two entries: pops shift entry 1 down, pushes fill the first free slot.
  always_comb begin
    entry0_d = entry0_q;
    entry1_d = entry1_q;
    count_d  = count_q;
    do_pop   = pop_i && (count_q != 2'd0);
    do_push  = push_i && ((count_q != 2'd2) || do_pop);
    case ({do_push, do_pop})
      2'b01: begin
        entry0_d = entry1_q;
        count_d  = count_q - 2'd1;
      end
      2'b10: begin
        if (count_q == 2'd0) entry0_d = push_data_i;
        else                 entry1_d = push_data_i;
        count_d = count_q + 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          entry0_d = push_data_i;
        end else begin
          entry0_d = entry1_q;
          entry1_d = push_data_i;
        end
      end
      default: ;
    endcase
  end

  // Storage registers, cleared on reset so discarded bytes never reappear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      entry0_q <= '0;
      entry1_q <= '0;
      count_q  <= 2'd0;
    end else begin
      entry0_q <= entry0_d;
      entry1_q <= entry1_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = entry0_q;
  assign count_o = count_q;

endmodule

// File: rtl/ft_tx_ctrl.sv
// Transmit controller: prefetches bytes from the async FIFO (1-cycle read
// latency), holds each byte on the FT2232H bus until accepted, and pulses
// SIWU# after an idle period to push partial USB packets to the host.
module ft_tx_ctrl import ft_pkg::*; #(
  parameter int DATA_WIDTH        = FT_DATA_WIDTH,
  parameter int FLUSH_IDLE_CYCLES = 64,
  parameter int CNT_WIDTH         = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  ft_tx_ctrl_if.master         bus,
  output logic [CNT_WIDTH-1:0] bytes_sent_o,
  output logic                 busy_o
);

  localparam int                IDLE_W   = $clog2(FLUSH_IDLE_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(FLUSH_IDLE_CYCLES);

  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  fifo_rden_q, fifo_rden_d;
  logic                  rd_pend_q, rd_pend_d;
  logic                  ft_wr_n_q, ft_wr_n_d;
  logic                  ft_siwua_n_q, ft_siwua_n_d;
  logic [CNT_WIDTH-1:0]  bytes_sent_q, bytes_sent_d;
  flush_state_e          state_q, state_d;
  logic [IDLE_W-1:0]     idle_cnt_q, idle_cnt_d;

  logic                  accept;
  logic                  skid_push;
  logic                  skid_pop;
  logic [DATA_WIDTH-1:0] skid_head;
  logic [1:0]            skid_count;
  logic [2:0]            level;

  // A byte leaves only when our strobe is low and the FT2232H has room at the same edge.
  assign accept = ~ft_wr_n_q & ~bus.ft_txe_n;

  assign busy_o = out_valid_q | (skid_count != 2'd0) | fifo_rden_q | rd_pend_q;

  ft_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (skid_push),
    .push_data_i (bus.fifo_rddata),
    .pop_i       (skid_pop),
    .head_o      (skid_head),
    .count_o     (skid_count)
  );

  // Read issue: keep buffered bytes plus reads in flight within the three storage slots.
  always_comb begin
    level = {2'b0, out_valid_q} + {1'b0, skid_count} + {2'b0, fifo_rden_q}
          + {2'b0, rd_pend_q} - {2'b0, accept};
    fifo_rden_d = enable_i & bus.ft_suspend_n & ~bus.fifo_empty & (level < 3'd3);
    rd_pend_d   = fifo_rden_q;
  end

  // Output register refill: oldest byte (skid head) first, then the returning read data.
  always_comb begin
    skid_push   = 1'b0;
    skid_pop    = 1'b0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (!out_valid_q || accept) begin
      if (skid_count != 2'd0) begin
        out_valid_d = 1'b1;
        out_data_d  = skid_head;
        skid_pop    = 1'b1;
        skid_push   = rd_pend_q;
      end else if (rd_pend_q) begin
        out_valid_d = 1'b1;
        out_data_d  = bus.fifo_rddata;
      end else begin
        out_valid_d = 1'b0;
      end
    end else begin
      skid_push = rd_pend_q;
    end
    ft_wr_n_d    = ~(out_valid_d & enable_i & bus.ft_suspend_n);
    bytes_sent_d = bytes_sent_q + CNT_WIDTH'(accept);
  end

  // Flush FSM: count idle cycles after the last acceptance, strobe SIWU# once when drained.
  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d    = ST_ACTIVE;
          idle_cnt_d = '0;
        end
      end
      ST_ACTIVE: begin
        if (accept) begin
          idle_cnt_d = '0;
        end else begin
          if (idle_cnt_q != IDLE_MAX) idle_cnt_d = idle_cnt_q + 1'b1;
          if ((idle_cnt_d == IDLE_MAX) && !busy_o) state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        idle_cnt_d = '0;
        state_d    = accept ? ST_ACTIVE : ST_IDLE;
      end
      default: begin
        state_d    = ST_IDLE;
        idle_cnt_d = '0;
      end
    endcase
    ft_siwua_n_d = (state_d != ST_FLUSH);
  end

  // All controller state, cleared asynchronously so outputs drop to idle immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      fifo_rden_q  <= 1'b0;
      rd_pend_q    <= 1'b0;
      ft_wr_n_q    <= 1'b1;
      ft_siwua_n_q <= 1'b1;
      bytes_sent_q <= '0;
      state_q      <= ST_IDLE;
      idle_cnt_q   <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      fifo_rden_q  <= fifo_rden_d;
      rd_pend_q    <= rd_pend_d;
      ft_wr_n_q    <= ft_wr_n_d;
      ft_siwua_n_q <= ft_siwua_n_d;
      bytes_sent_q <= bytes_sent_d;
      state_q      <= state_d;
      idle_cnt_q   <= idle_cnt_d;
    end
  end

  assign bus.fifo_rden  = fifo_rden_q;
  assign bus.ft_wr_n    = ft_wr_n_q;
  assign bus.ft_data    = out_data_q;
  assign bus.ft_siwua_n = ft_siwua_n_q;
  assign bytes_sent_o   = bytes_sent_q;

endmodule

// File: tb/tb_ft_tx_ctrl.sv
// Directed bench for ft_tx_ctrl with a behavioural async-FIFO read port
// and an acceptance monitor on the FT2232H side.
module tb_ft_tx_ctrl;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [31:0] bytes_sent;
  logic        busy;

  int checks = 0;
  int errors = 0;

  ft_tx_ctrl_if #(.DATA_WIDTH(8)) bus ();

  ft_tx_ctrl #(
    .DATA_WIDTH        (8),
    .FLUSH_IDLE_CYCLES (64),
    .CNT_WIDTH         (32)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .enable_i     (enable),
    .bus          (bus),
    .bytes_sent_o (bytes_sent),
    .busy_o       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [0:1023];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  logic       fifo_clear = 1'b1;
  logic       toggle_en = 1'b0;
  logic       empty_toggle = 1'b0;
  logic       prev_empty = 1'b1;
  int         read_viol = 0;
  logic [7:0] acc [$];

  // Empty flag looks past a read already strobed, plus an optional toggling mask.
  assign bus.fifo_empty = empty_toggle | ((wr_ptr - rd_ptr - (bus.fifo_rden ? 1 : 0)) <= 0);

  // FIFO read port model: data for a strobed read appears the following cycle.
  always @(posedge clk) begin
    if (fifo_clear) begin
      rd_ptr <= 0;
    end else if (bus.fifo_rden) begin
      bus.fifo_rddata <= mem[rd_ptr];
      rd_ptr          <= rd_ptr + 1;
    end
    if (bus.fifo_rden && (prev_empty || (rd_ptr >= wr_ptr))) read_viol <= read_viol + 1;
    prev_empty   <= bus.fifo_empty;
    empty_toggle <= toggle_en ? ~empty_toggle : 1'b0;
  end

  // Record every byte the FT2232H takes.
  always @(posedge clk) begin
    if (!rst && !bus.ft_wr_n && !bus.ft_txe_n) acc.push_back(bus.ft_data);
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [7:0] pattern(input int kind, input int i);
    if (kind == 0) return 8'(i);
    return 8'(i * 37 + 5);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input int n, input int kind);
    rst = 1'b1;
    fifo_clear = 1'b1;
    acc.delete();
    step();
    fifo_clear = 1'b0;
    for (int i = 0; i < n; i++) mem[i] = pattern(kind, i);
    wr_ptr = n;
    step();
    rst = 1'b0;
  endtask

  task automatic wait_bytes(input int target, input int budget, input string tag);
    int n = 0;
    while (int'(bytes_sent) < target && n < budget) begin
      step();
      n++;
    end
    check_output({tag, " byte target reached"}, 64'(int'(bytes_sent) >= target), 64'd1);
  endtask

  task automatic check_stream(input string tag, input int n, input int base, input int kind);
    check_output({tag, " accepted count"}, 64'(acc.size()), 64'(n));
    for (int i = 0; i < n && i < acc.size(); i++)
      check_output({tag, " accepted byte"}, 64'(acc[i]), 64'(pattern(kind, base + i)));
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, " wr_n"}, 64'(bus.ft_wr_n), 64'd1);
    check_output({tag, " siwua_n"}, 64'(bus.ft_siwua_n), 64'd1);
    check_output({tag, " rden"}, 64'(bus.fifo_rden), 64'd0);
    check_output({tag, " data"}, 64'(bus.ft_data), 64'd0);
    check_output({tag, " bytes_sent"}, 64'(bytes_sent), 64'd0);
    check_output({tag, " busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int n;
    int lows;
    int first_low;
    int bad;
    int head;

    rst = 1'b1;
    enable = 1'b1;
    bus.ft_txe_n = 1'b0;
    bus.ft_suspend_n = 1'b1;
    #2;
    check_reset_values("reset");

    // 256-byte stream, TXE# low throughout
    $display("[TB] stream of 256 bytes");
    apply_stimulus(256, 0);
    step();
    check_output("first read strobe", 64'(bus.fifo_rden), 64'd1);
    check_output("wr_n before data", 64'(bus.ft_wr_n), 64'd1);
    step();
    check_output("wr_n during read latency", 64'(bus.ft_wr_n), 64'd1);
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      step();
      if (bus.ft_wr_n !== 1'b0 || bus.ft_data !== 8'(i)) bad++;
    end
    check_output("stream 1 byte per cycle", 64'(bad), 64'd0);
    step();
    check_output("wr_n after last byte", 64'(bus.ft_wr_n), 64'd1);
    check_output("bytes_sent after 256", 64'(bytes_sent), 64'd256);
    check_output("busy after drain", 64'(busy), 64'd0);
    check_stream("stream256", 256, 0, 0);

    // TXE# stall while 0x40 is presented
    $display("[TB] TXE# stall");
    apply_stimulus(256, 0);
    n = 0;
    while (!(bus.ft_data === 8'h40 && bus.ft_wr_n === 1'b0) && n < 200) begin
      step();
      n++;
    end
    check_output("byte 0x40 presented", 64'(bus.ft_data), 64'h40);
    check_output("bytes before stall", 64'(bytes_sent), 64'd64);
    bus.ft_txe_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (bus.ft_data !== 8'h40 || bytes_sent !== 32'd64) bad++;
    end
    check_output("hold during TXE# high", 64'(bad), 64'd0);
    bus.ft_txe_n = 1'b0;
    wait_bytes(80, 200, "stall");
    check_stream("stall", 80, 0, 0);

    // Ten bytes, then idle: exactly one SIWU# strobe
    $display("[TB] flush after idle");
    apply_stimulus(10, 0);
    wait_bytes(10, 50, "flush");
    lows = 0;
    first_low = 0;
    for (int k = 1; k <= 200; k++) begin
      step();
      if (bus.ft_siwua_n === 1'b0) begin
        lows++;
        if (first_low == 0) first_low = k;
      end
    end
    check_output("flush strobe position", 64'(first_low), 64'd64);
    check_output("flush strobe count", 64'(lows), 64'd1);
    check_output("bytes after flush", 64'(bytes_sent), 64'd10);

    // Suspend for 20 cycles mid-stream
    $display("[TB] suspend");
    apply_stimulus(256, 0);
    wait_bytes(20, 100, "suspend start");
    bus.ft_suspend_n = 1'b0;
    step();
    check_output("suspend wr_n", 64'(bus.ft_wr_n), 64'd1);
    check_output("suspend rden", 64'(bus.fifo_rden), 64'd0);
    check_output("suspend busy", 64'(busy), 64'd1);
    bad = 0;
    for (int i = 0; i < 19; i++) begin
      step();
      if (bus.ft_wr_n !== 1'b1 || bus.fifo_rden !== 1'b0 || busy !== 1'b1) bad++;
    end
    check_output("suspend hold", 64'(bad), 64'd0);
    bus.ft_suspend_n = 1'b1;
    wait_bytes(60, 200, "resume");
    check_stream("resume", 60, 0, 0);

    // Asynchronous reset between edges
    $display("[TB] async reset");
    apply_stimulus(256, 0);
    wait_bytes(30, 100, "pre-reset");
    #3;
    rst = 1'b1;
    #1;
    check_reset_values("async reset");
    head = rd_ptr;
    acc.delete();
    step();
    step();
    rst = 1'b0;
    wait_bytes(20, 100, "post-reset");
    check_output("bytes after restart", 64'(bytes_sent), 64'd20);
    check_stream("restart", 20, head, 0);

    // Toggling empty flag with random TXE#
    $display("[TB] toggling empty");
    toggle_en = 1'b1;
    apply_stimulus(64, 1);
    n = 0;
    while (int'(bytes_sent) < 64 && n < 3000) begin
      bus.ft_txe_n = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    bus.ft_txe_n = 1'b0;
    toggle_en = 1'b0;
    check_output("toggle byte target reached", 64'(bytes_sent), 64'd64);
    check_stream("toggle", 64, 0, 1);
    step();
    check_output("no read while empty", 64'(read_viol), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
